axis_splitter: RTL and testbench

// Splits one AXIS packet into NUM_STREAMS consecutive sub-packets, one per output stream, in

---
 rtl/axis_splitter.sv | 112 +++++++++++
 tb/tb_axis_splitter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/axis_splitter.sv
// rtl/axis_splitter.sv - splits one AXIS packet into NUM_STREAMS length-defined sub-packets
module axis_splitter #(
  parameter int AXIS_BYTES     = 1,
  parameter int AXIS_USER_BITS = 1,
  parameter int NUM_STREAMS    = 1,
  parameter int LEN_BITS       = 16
) (
  input  logic                                  clk,
  input  logic                                  sresetn,
  input  logic                                  axis_i_tvalid,
  output logic                                  axis_i_tready,
  input  logic                                  axis_i_tlast,
  input  logic [AXIS_BYTES-1:0]                 axis_i_tkeep,
  input  logic [8*AXIS_BYTES-1:0]               axis_i_tdata,
  input  logic [AXIS_USER_BITS-1:0]             axis_i_tuser,
  output logic [NUM_STREAMS-1:0]                axis_o_tvalid,
  input  logic [NUM_STREAMS-1:0]                axis_o_tready,
  output logic [NUM_STREAMS-1:0]                axis_o_tlast,
  output logic [NUM_STREAMS*AXIS_BYTES-1:0]     axis_o_tkeep,
  output logic [NUM_STREAMS*8*AXIS_BYTES-1:0]   axis_o_tdata,
  output logic [NUM_STREAMS*AXIS_USER_BITS-1:0] axis_o_tuser,
  input  logic [NUM_STREAMS*LEN_BITS-1:0]       lengths_i,
  output logic                                  err_o
);
  localparam int CW = $clog2(NUM_STREAMS + 1);

  typedef enum logic [1:0] {LOAD, SKIP_CHK, STREAM, DRAIN} state_t;

  state_t              state;
  logic [CW-1:0]       ctr;
  logic [LEN_BITS-1:0] beat_ctr;
  logic [LEN_BITS-1:0] len_q [NUM_STREAMS];
  logic [LEN_BITS-1:0] cur_len;
  logic [LEN_BITS-1:0] cur_len_m1;
  logic                rest_zero;
  logic                seg_last;
  logic                hs;
  logic [NUM_STREAMS-1:0] sel;

  // Current segment length and whether every later segment is empty.
  always_comb begin
    cur_len   = '0;
    rest_zero = 1'b1;
    sel       = '0;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      if (ctr == CW'(i)) cur_len = len_q[i];
      if (CW'(i) > ctr && len_q[i] != '0) rest_zero = 1'b0;
      sel[i] = (state == STREAM) && (ctr == CW'(i));
    end
  end

  assign cur_len_m1 = cur_len - LEN_BITS'(1);
  assign seg_last   = (beat_ctr == cur_len_m1);

  assign axis_o_tvalid = sel & {NUM_STREAMS{axis_i_tvalid}};
  assign axis_o_tlast  = sel & {NUM_STREAMS{seg_last | axis_i_tlast}};
  assign axis_o_tdata  = {NUM_STREAMS{axis_i_tdata}};
  assign axis_o_tkeep  = {NUM_STREAMS{axis_i_tkeep}};
  assign axis_o_tuser  = {NUM_STREAMS{axis_i_tuser}};
  assign axis_i_tready = (state == DRAIN) | (|(sel & axis_o_tready));
  assign hs            = axis_i_tvalid & axis_i_tready;

  always_ff @(posedge clk) begin
    if (!sresetn) begin
      state    <= LOAD;
      ctr      <= '0;
      beat_ctr <= '0;
      err_o    <= 1'b0;
    end else begin
      err_o <= 1'b0;
      case (state)
        LOAD: begin
          for (int i = 0; i < NUM_STREAMS; i++)
            len_q[i] <= lengths_i[(i+1)*LEN_BITS-1 -: LEN_BITS];
          ctr   <= '0;
          state <= SKIP_CHK;
        end
        SKIP_CHK: begin
          if (ctr == CW'(NUM_STREAMS)) begin
            state <= DRAIN;
          end else if (cur_len == '0) begin
            ctr <= ctr + CW'(1);
          end else begin
            beat_ctr <= '0;
            state    <= STREAM;
          end
        end
        STREAM: begin
          if (hs) begin
            // Input tlast always ends the packet; it is clean only at the final segment's end.
            if (axis_i_tlast) begin
              err_o <= !(seg_last && rest_zero);
              state <= LOAD;
            end else if (seg_last) begin
              ctr   <= ctr + CW'(1);
              state <= SKIP_CHK;
            end else begin
              beat_ctr <= beat_ctr + LEN_BITS'(1);
            end
          end
        end
        DRAIN: begin
          if (hs && axis_i_tlast) begin
            err_o <= 1'b1;
            state <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_splitter.sv
// tb/tb_axis_splitter.sv - randomized self-checking bench for axis_splitter
`timescale 1ns/1ps
module tb_axis_splitter;
  localparam int N = 3;

  logic          clk = 1'b0;
  logic          sresetn;
  logic          axis_i_tvalid, axis_i_tready, axis_i_tlast;
  logic [0:0]    axis_i_tkeep;
  logic [7:0]    axis_i_tdata;
  logic [0:0]    axis_i_tuser;
  logic [N-1:0]  axis_o_tvalid, axis_o_tready, axis_o_tlast;
  logic [N-1:0]  axis_o_tkeep;
  logic [8*N-1:0] axis_o_tdata;
  logic [N-1:0]  axis_o_tuser;
  logic [8*N-1:0] lengths_i;
  logic          err_o;

  int total = 0;
  int bad   = 0;
  int err_cnt, drop_cnt;
  bit bp, gaps, hold_ready;
  int lens_now [N];
  // Expected entry: {tuser, tkeep, tlast, tdata}
  logic [10:0] exp_q [N][$];

  axis_splitter #(.AXIS_BYTES(1), .AXIS_USER_BITS(1), .NUM_STREAMS(N), .LEN_BITS(8)) dut (
    .clk(clk), .sresetn(sresetn),
    .axis_i_tvalid(axis_i_tvalid), .axis_i_tready(axis_i_tready), .axis_i_tlast(axis_i_tlast),
    .axis_i_tkeep(axis_i_tkeep), .axis_i_tdata(axis_i_tdata), .axis_i_tuser(axis_i_tuser),
    .axis_o_tvalid(axis_o_tvalid), .axis_o_tready(axis_o_tready), .axis_o_tlast(axis_o_tlast),
    .axis_o_tkeep(axis_o_tkeep), .axis_o_tdata(axis_o_tdata), .axis_o_tuser(axis_o_tuser),
    .lengths_i(lengths_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    axis_o_tready = '1;
    forever begin
      @(posedge clk);
      #1;
      axis_o_tready = hold_ready ? '0 : (bp ? N'($urandom) : '1);
    end
  end

  always @(negedge clk) begin
    if (sresetn) begin
      if (axis_o_tvalid != '0) check("onehot_tvalid", $countones(axis_o_tvalid) <= 1, 1);
      for (int i = 0; i < N; i++) begin
        if (axis_o_tvalid[i] && axis_o_tready[i]) begin
          if (exp_q[i].size() == 0)
            check($sformatf("unexpected_beat_o%0d", i), exp_q[i].size(), 1);
          else
            check($sformatf("beat_o%0d", i),
                  {axis_o_tuser[i], axis_o_tkeep[i], axis_o_tlast[i], axis_o_tdata[i*8 +: 8]},
                  exp_q[i].pop_front());
        end
      end
      if (axis_i_tvalid && axis_i_tready && axis_o_tvalid == '0) drop_cnt++;
      if (err_o) err_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic set_lens(input int a, input int b, input int c);
    lens_now[0] = a; lens_now[1] = b; lens_now[2] = c;
    lengths_i = {8'(c), 8'(b), 8'(a)};
  endtask

  task automatic drive_beat(input logic [10:0] b, input bit last);
    int w;
    if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    axis_i_tvalid = 1'b1;
    axis_i_tdata  = b[7:0];
    axis_i_tkeep  = b[9];
    axis_i_tuser  = b[10];
    axis_i_tlast  = last;
    w = 0;
    @(negedge clk);
    while (!axis_i_tready && w < 2000) begin @(negedge clk); w++; end
    if (!axis_i_tready) check("handshake_timeout", axis_i_tready, 1);
    @(posedge clk);
    #1;
    axis_i_tvalid = 1'b0;
    axis_i_tlast  = 1'b0;
  endtask

  // Sends a p-beat packet split by lens_now, then loads the next packet's lengths.
  task automatic run_packet(input int p, input int n0, input int n1, input int n2);
    logic [10:0] pk [$];
    logic [10:0] e;
    int pos, sum, exp_drop;
    bit exp_err;
    for (int b = 0; b < p; b++) begin
      e = 11'($urandom);
      e[8] = (b == p - 1);
      pk.push_back(e);
    end
    pos = 0; sum = 0;
    for (int s = 0; s < N; s++) begin
      sum += lens_now[s];
      for (int k = 0; k < lens_now[s]; k++) begin
        if (pos < p) begin
          e = pk[pos];
          e[8] = (k == lens_now[s] - 1) || (pos == p - 1);
          exp_q[s].push_back(e);
          pos++;
        end
      end
    end
    exp_drop = p - pos;
    exp_err  = (p != sum);
    err_cnt = 0; drop_cnt = 0;
    for (int b = 0; b < p; b++) begin
      drive_beat(pk[b], b == p - 1);
      if (b == p - 1) set_lens(n0, n1, n2);
    end
    repeat (3) @(posedge clk);
    #1;
    check("err_pulses", err_cnt, exp_err ? 1 : 0);
    check("dropped_beats", drop_cnt, exp_drop);
    check("leftover_beats", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 0);
    for (int s = 0; s < N; s++) exp_q[s].delete();
  endtask

  initial begin
    int a, b, c, s, p;
    sresetn = 1'b0;
    axis_i_tvalid = 1'b0; axis_i_tlast = 1'b0;
    axis_i_tdata = '0; axis_i_tkeep = '0; axis_i_tuser = '0;
    bp = 1'b0; gaps = 1'b0; hold_ready = 1'b0;
    err_cnt = 0; drop_cnt = 0;
    set_lens(2, 3, 1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_tready", axis_i_tready, 0);
    check("rst_tvalid", axis_o_tvalid, 0);
    check("rst_err", err_o, 0);
    sresetn = 1'b1;

    run_packet(6, 2, 0, 2);   // {2,3,1} exact fit
    run_packet(4, 3, 3, 0);   // {2,0,2} skip empty middle segment
    run_packet(4, 1, 1, 0);   // {3,3,0} short packet ends in segment 1
    run_packet(4, 0, 0, 0);   // {1,1,0} long packet, two beats drained
    run_packet(3, 4, 4, 4);   // {0,0,0} whole packet dropped

    // Reset in the middle of segment 0 of a {4,4,4} packet.
    for (int k = 0; k < 2; k++) begin
      a = $urandom_range(0, 255);
      exp_q[0].push_back({3'b110, 8'(a)});
      drive_beat({3'b110, 8'(a)}, 1'b0);
    end
    hold_ready = 1'b1;
    axis_o_tready = '0;
    axis_i_tvalid = 1'b1;
    sresetn = 1'b0;
    set_lens(2, 3, 1);
    @(posedge clk);
    #1;
    sresetn = 1'b1;
    check("midrst_tvalid", axis_o_tvalid, 0);
    check("midrst_err", err_o, 0);
    check("midrst_tready", axis_i_tready, 0);
    check("midrst_seg0_beats", exp_q[0].size(), 0);
    axis_i_tvalid = 1'b0;
    hold_ready = 1'b0;
    for (int i = 0; i < N; i++) exp_q[i].delete();

    a = $urandom_range(0, 3); b = $urandom_range(0, 3); c = $urandom_range(0, 3);
    run_packet(6, a, b, c);   // {2,3,1} after reset starts from out0

    bp = 1'b1; gaps = 1'b1;
    for (int n = 0; n < 200; n++) begin
      s = lens_now[0] + lens_now[1] + lens_now[2];
      if ($urandom_range(0, 9) < 7) p = s;
      else p = $urandom_range(1, s + 3);
      if (p == 0) p = 1;
      a = $urandom_range(0, 3); b = $urandom_range(0, 3); c = $urandom_range(0, 3);
      run_packet(p, a, b, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
